// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared definitions for the CPU/DMA memory bus arbiter.
//   state_t          - arbiter owner encoding, also driven out on the owner port
//   MAX_HOLD_DEFAULT - default number of back-to-back grants one owner may take
//                      while the other port is waiting
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_DMA  = 2'd2
    } state_t;

    localparam int MAX_HOLD_DEFAULT = 4;

endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-port (CPU, DMA) arbiter in front of one synchronous RAM.
//
// Ports
//   clk, reset              - clock; asynchronous active-high reset
//   cpu_req/we/addr/wdata   - CPU access request
//   cpu_gnt                 - access issued to RAM this cycle
//   cpu_rvalid, cpu_rdata   - read data return, one cycle after a granted read
//   dma_*                   - identical port for the DMA engine
//   mem_addr/we/wdata       - shared RAM command (all zero when nobody is granted)
//   mem_rdata               - RAM read data, valid one cycle after the address
//   owner                   - 0 idle, 1 CPU, 2 DMA
//
// Parameter MAX_HOLD (1..15): max consecutive grants to one owner while the
// other port is requesting.
//
// Build option ARB_CPU_PRIORITY_EN: when defined, CPU wins every tie, preempts
// DMA after DMA's current granted cycle and ignores MAX_HOLD. When undefined,
// ties alternate with the last owner and MAX_HOLD applies to both ports.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [7:0]  cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [7:0]  dma_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [1:0]  owner
);

`ifdef ARB_CPU_PRIORITY_EN
    localparam bit CPU_PRIO = 1'b1;
`else
    localparam bit CPU_PRIO = 1'b0;
`endif

    localparam logic [3:0] HOLD_MAX  = 4'(MAX_HOLD);
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    function automatic logic [3:0] hold_sat_inc(input logic [3:0] cnt, input logic [3:0] lim);
        hold_sat_inc = (cnt >= lim) ? lim : cnt + 4'd1;
    endfunction

    state_t     state, state_nxt, last_owner;
    logic [3:0] hold_cnt;
    logic       hold_last;
    logic       cpu_vld_p1, dma_vld_p1;
    logic [7:0] cpu_rdata_p1, dma_rdata_p1;

    assign cpu_gnt = (state == ST_CPU) && cpu_req;
    assign dma_gnt = (state == ST_DMA) && dma_req;
    assign owner   = state;

    // ">=" rather than "==": a counter that saturated while the other port was
    // idle must still yield as soon as the other port starts requesting.
    assign hold_last = (hold_cnt >= HOLD_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cpu_req && dma_req)
                    state_nxt = (CPU_PRIO || last_owner == ST_DMA) ? ST_CPU : ST_DMA;
                else if (cpu_req)
                    state_nxt = ST_CPU;
                else if (dma_req)
                    state_nxt = ST_DMA;
            end
            ST_CPU: begin
                if (!cpu_req)
                    state_nxt = dma_req ? ST_DMA : ST_IDLE;
                else if (dma_req && !CPU_PRIO && hold_last)
                    state_nxt = ST_DMA;
            end
            ST_DMA: begin
                if (!dma_req)
                    state_nxt = cpu_req ? ST_CPU : ST_IDLE;
                else if (cpu_req && (CPU_PRIO || hold_last))
                    state_nxt = ST_CPU;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_owner <= ST_DMA;
            hold_cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state != ST_IDLE)
                last_owner <= state;
            if (state_nxt != state)
                hold_cnt <= 4'd0;
            else if (cpu_gnt || dma_gnt)
                hold_cnt <= hold_sat_inc(hold_cnt, HOLD_MAX);
        end
    end

    always_comb begin
        mem_addr  = 16'd0;
        mem_we    = 1'b0;
        mem_wdata = 8'd0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end else if (dma_gnt) begin
            mem_addr  = dma_addr;
            mem_we    = dma_we;
            mem_wdata = dma_wdata;
        end
    end

    // Stage p0 -> p1: granted read in flight; RAM data arrives during p1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_vld_p1   <= 1'b0;
            dma_vld_p1   <= 1'b0;
            cpu_rdata_p1 <= 8'd0;
            dma_rdata_p1 <= 8'd0;
        end else begin
            cpu_vld_p1 <= cpu_gnt && !cpu_we;
            dma_vld_p1 <= dma_gnt && !dma_we;
            if (cpu_vld_p1)
                cpu_rdata_p1 <= mem_rdata;
            if (dma_vld_p1)
                dma_rdata_p1 <= mem_rdata;
        end
    end

    // Present RAM data directly in the rvalid cycle, then hold the captured copy.
    assign cpu_rvalid = cpu_vld_p1;
    assign dma_rvalid = dma_vld_p1;
    assign cpu_rdata  = cpu_vld_p1 ? mem_rdata : cpu_rdata_p1;
    assign dma_rdata  = dma_vld_p1 ? mem_rdata : dma_rdata_p1;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench for mem_bus_arbiter (MAX_HOLD = 4) with a
// behavioural synchronous RAM model attached to the mem_* port.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, dma_addr, mem_addr;
    logic [7:0]  cpu_wdata, dma_wdata, mem_wdata, mem_rdata;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_we;
    logic [7:0]  cpu_rdata, dma_rdata;
    logic [1:0]  owner;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] ram [0:65535];

    always #5 clk = ~clk;

    mem_bus_arbiter #(.MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    // Synchronous RAM: read data valid one cycle after the address
    always @(posedge clk) begin
        if (mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h1234] = 8'hA5;
        ram[16'h0010] = 8'h3C;
        ram[16'h0020] = 8'hC3;
        mem_rdata = 8'h00;

        // ---------------- reset state
        do_reset();
        #1;
        chk("rst_owner", owner, 0);
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_dma_gnt", dma_gnt, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);

        // ---------------- case 1: lone CPU read of 0x1234
        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234; #1;
        chk("c1_gnt_c0", cpu_gnt, 0);
        tick(); #1;
        chk("c1_gnt_c1", cpu_gnt, 1);
        chk("c1_owner", owner, 1);
        chk("c1_mem_addr", mem_addr, 16'h1234);
        tick();
        cpu_req = 0; #1;
        chk("c1_rvalid", cpu_rvalid, 1);
        chk("c1_rdata", cpu_rdata, 8'hA5);
        chk("c1_gnt_off", cpu_gnt, 0);
        tick(); #1;
        chk("c1_rvalid_once", cpu_rvalid, 0);
        chk("c1_rdata_hold", cpu_rdata, 8'hA5);
        chk("c1_idle", owner, 0);

`ifndef ARB_CPU_PRIORITY_EN
        // ---------------- case 2: simultaneous requests, hold limit 4
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        dma_req = 1; dma_we = 0; dma_addr = 16'h0020; #1;
        chk("c2_idle_owner", owner, 0);
        chk("c2_idle_gnt", cpu_gnt | dma_gnt, 0);
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            chk($sformatf("c2_cpu_gnt%0d", k), {owner, cpu_gnt, dma_gnt}, {2'd1, 1'b1, 1'b0});
        end
        tick(); #1;
        chk("c2_dma_owner", {owner, cpu_gnt, dma_gnt}, {2'd2, 1'b0, 1'b1});
        chk("c2_cpu_last_rvalid", cpu_rvalid, 1);
        chk("c2_cpu_last_rdata", cpu_rdata, 8'h3C);
        tick();
        cpu_req = 0; dma_req = 0; #1;
        chk("c2_dma_rvalid", dma_rvalid, 1);
        chk("c2_dma_rdata", dma_rdata, 8'hC3);
        chk("c2_cpu_rvalid_off", cpu_rvalid, 0);
        tick(); #1;
        chk("c2_back_idle", owner, 0);
`endif

        // ---------------- case 3: DMA write then CPU read of 0x0200
        do_reset();
        dma_req = 1; dma_we = 1; dma_addr = 16'h0200; dma_wdata = 8'h5A; #1;
        chk("c3_we_before", mem_we, 0);
        tick(); #1;
        chk("c3_dma_gnt", dma_gnt, 1);
        chk("c3_we_grant", mem_we, 1);
        chk("c3_wr_bus", {mem_addr, mem_wdata}, {16'h0200, 8'h5A});
        tick();
        dma_req = 0; dma_we = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0200; #1;
        chk("c3_we_after", mem_we, 0);
        chk("c3_no_dma_rvalid", dma_rvalid, 0);
        tick(); #1;
        chk("c3_cpu_gnt", {owner, cpu_gnt}, {2'd1, 1'b1});
        chk("c3_we_read", mem_we, 0);
        tick();
        cpu_req = 0; #1;
        chk("c3_rvalid", cpu_rvalid, 1);
        chk("c3_rdata", cpu_rdata, 8'h5A);

        // ---------------- case 4: reset right after a granted read
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
        tick(); #1;
        chk("c4_gnt", cpu_gnt, 1);
        tick();
        reset = 1; #1;
        chk("c4_rvalid", cpu_rvalid, 0);
        chk("c4_owner", owner, 0);
        chk("c4_gnt_off", cpu_gnt, 0);
        chk("c4_rdata", cpu_rdata, 0);
        chk("c4_mem", {mem_addr, mem_we, mem_wdata}, 0);
        tick();
        reset = 0; cpu_req = 0;
        tick(); #1;
        chk("c4_rvalid_after", cpu_rvalid, 0);

`ifdef ARB_CPU_PRIORITY_EN
        // ---------------- case 5: CPU preempts DMA and is never limited
        do_reset();
        dma_req = 1; dma_we = 0; dma_addr = 16'h0020;
        tick(); #1;
        chk("c5_dma_gnt", dma_gnt, 1);
        tick();
        cpu_req = 1; cpu_addr = 16'h0010; #1;
        chk("c5_dma_last", dma_gnt, 1);
        for (int k = 0; k < 8; k++) begin
            tick(); #1;
            chk($sformatf("c5_cpu_hold%0d", k), {owner, cpu_gnt, dma_gnt}, {2'd1, 1'b1, 1'b0});
        end
        idle_inputs();
`endif

        // ---------------- case 6: owner drops request, other port idle
        do_reset();
        dma_req = 1; dma_we = 1; dma_addr = 16'h0300; dma_wdata = 8'h11;
        tick(); #1;
        chk("c6_gnt0", dma_gnt, 1);
        tick();
        dma_addr = 16'h0301; #1;
        chk("c6_gnt1", {dma_gnt, mem_addr}, {1'b1, 16'h0301});
        tick();
        dma_req = 0; #1;
        chk("c6_drop_gnt", dma_gnt, 0);
        chk("c6_drop_bus", {mem_we, mem_addr}, 0);
        tick(); #1;
        chk("c6_idle", owner, 0);
        chk("c6_idle_bus", {mem_we, mem_addr}, 0);
        chk("c6_ram", ram[16'h0301], 8'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 4: max consecutive granted cycles for one owner while the other port waits (legal range 1..15).
REQ-002 SHALL have ports clk (in, 1, clock) and reset (in, 1, reset); reset is asynchronous and active-high, and clk is the clock.
REQ-003 SHALL have cpu_req, cpu_we (in, 1 each): CPU access request and write enable.
REQ-004 SHALL have cpu_addr (in, 16) and cpu_wdata (in, 8): CPU address and write data.
REQ-005 SHALL have cpu_gnt, cpu_rvalid (out, 1 each) and cpu_rdata (out, 8): CPU access-issued strobe, read-data-valid strobe and read data.
REQ-006 SHALL have dma_req, dma_we, dma_addr[15:0], dma_wdata[7:0], dma_gnt, dma_rvalid, dma_rdata[7:0], with the same directions and meanings as the CPU port.
REQ-007 SHALL have mem_addr (out, 16), mem_we (out, 1), mem_wdata (out, 8): shared synchronous RAM address, write strobe and write data.
REQ-008 SHALL have mem_rdata (in, 8): RAM read data, valid one cycle after the address.
REQ-009 SHALL have owner (out, 2): 0 = IDLE, 1 = CPU, 2 = DMA.

Function
REQ-010 SHALL implement a registered FSM with states IDLE, CPU and DMA.
REQ-011 SHALL assert x_gnt = (state==x) & x_req combinationally; each cycle with gnt high issues exactly one access.
REQ-012 SHALL drive mem_* from the owning port while its gnt is high, and otherwise drive mem_addr=0, mem_we=0 and mem_wdata=0.
REQ-013 SHALL pulse x_rvalid for one cycle, exactly one cycle after a granted read (we=0), with x_rdata = mem_rdata.
REQ-014 SHALL hold x_rdata between reads, and SHALL NOT pulse rvalid for writes.
REQ-015 From IDLE, SHALL move to the sole requester; with both requesting, SHALL move to the port that was not the last owner (last_owner resets to DMA, so CPU wins first).
REQ-016 SHALL give a first grant exactly one cycle after req rises from IDLE.
REQ-017 SHALL keep a 4-bit hold_cnt, cleared on every state change and incremented per granted cycle, saturating at MAX_HOLD.
REQ-018 While in owner X: if X_req=0, SHALL go to the other port if it is requesting, else to IDLE.
REQ-019 While in owner X: if hold_cnt==MAX_HOLD-1 on a granted cycle and the other port is requesting, SHALL switch to the other port next cycle.
REQ-020 SHALL NOT apply the hold limit while the other port is not requesting.
REQ-021 SHALL allow switching directly between CPU and DMA without passing through IDLE.
REQ-022 A read issued in the last cycle before a switch SHALL still return rvalid to its issuer.
REQ-023 If req drops during ownership, SHALL issue no access in that cycle.

Reset
REQ-024 On reset, SHALL immediately force state=IDLE, owner=0, hold_cnt=0, last_owner=DMA, all gnt/rvalid=0, rdata=0 and mem_*=0.
REQ-025 A read in flight at reset SHALL be discarded with no rvalid.

Configuration
REQ-026 With ARB_CPU_PRIORITY_EN defined: CPU SHALL win every tie, SHALL preempt DMA after DMA's current granted cycle, and SHALL be exempt from MAX_HOLD.
REQ-027 Without ARB_CPU_PRIORITY_EN: round-robin plus MAX_HOLD fairness SHALL apply per REQ-015..REQ-021.

Structure
REQ-028 SHALL place state encodings (IDLE/CPU/DMA) and the default MAX_HOLD in a shared package, mem_bus_pkg.
REQ-029 SHALL have no sub-module; the owner/hold logic is flat, and the single read-return pipeline stage is a register inside the block.

Verification
REQ-030 Case 1: cpu_req=1 alone, read 0x1234, RAM holds 0xA5 -> cpu_gnt next cycle, cpu_rvalid one cycle later, cpu_rdata=0xA5.
REQ-031 Case 2: cpu_req and dma_req rise in the same cycle after reset -> CPU granted first; with MAX_HOLD=4, exactly 4 CPU grants, then DMA owner with no gap.
REQ-032 Case 3: DMA write 0x5A to 0x0200, then CPU read of 0x0200 -> cpu_rdata=0x5A, and mem_we high only in the DMA grant cycle.
REQ-033 Case 4: CPU read granted, reset asserted in the next cycle -> no cpu_rvalid, all outputs 0, owner=0.
REQ-034 Case 5 (ARB_CPU_PRIORITY_EN defined): DMA owner with cpu_req rising -> DMA gets at most one more grant, then CPU holds indefinitely.
REQ-035 Case 6: owner drops req mid-burst while the other port is idle -> IDLE next cycle, mem_we=0, mem_addr=0.
